gf_vme_multi_pulse_decoder: RTL and testbench
=============================================

Name: gf_vme_multi_pulse_decoder

Overview:
- Parametrised multi-channel VME read/write strobe decoder.
- Decodes a window of N_CH registers starting at a runtime base address and emits one single-cycle, one-hot read or write pulse per qualified VME access.
- Adds strobe synchronisation, minimum-width deglitching, collision detection and a miss counter.
- Sits between the VME slave interface and the register/command logic of the gigafitter board.

Parameters:
- ADDR_W, 16, address and base width.
- N_CH, 8, number of decoded channels (1..32).
- STRIDE_LOG2, 1, channel address stride = 2**STRIDE_LOG2 (byte/word spacing).
- SYNC_STAGES, 2, flops on access strobes before use (0..3; 0 = no synchroniser).
- MIN_ACCESS, 2, consecutive synchronised-high cycles needed to qualify an access (1..15).
- MISS_W, 8, width of the saturating miss counter.

Ports:
- clk  in  1  system clock.
- init  in  1  synchronous active-high reset.
- address  in  ADDR_W  VME address, stable while an access strobe is high.
- base_address  in  ADDR_W  start of the decoded window.
- writeAccess  in  1  VME write strobe, may be asynchronous.
- readAccess  in  1  VME read strobe, may be asynchronous.
- writePulse  out  N_CH  one-hot, 1-cycle write pulse.
- readPulse  out  N_CH  one-hot, 1-cycle read pulse.
- pulse_channel  out  log2(N_CH) (min 1)  index of the last pulsed channel, held until the next pulse.
- access_error  out  1  1-cycle pulse on read/write collision.
- miss_count  out  MISS_W  saturating count of qualified accesses outside the window.

Behaviour:
- Single clock; init is synchronous and active-high. All registers are updated only on the rising edge of clk.
- Reset values:
  - writePulse, readPulse, pulse_channel, access_error, miss_count, synchroniser flops and qualify counter = 0.
  - FSM = ARM.
- Synchroniser: wr_s/rd_s are the strobes delayed by SYNC_STAGES flops; with SYNC_STAGES=0 they equal the raw inputs.
- Decode, combinational on raw address:
  - off = address - base_address, modulo 2**ADDR_W (wrap-around is a miss unless it lands in the window).
  - hit = (off >> STRIDE_LOG2) < N_CH and the low STRIDE_LOG2 bits of off are zero.
  - ch = off >> STRIDE_LOG2.
- FSM states:
  - ARM: wait until wr_s=0 and rd_s=0, then go to IDLE. This prevents a spurious pulse when reset is released mid-access.
  - IDLE: if wr_s or rd_s is high, set cnt=1. If MIN_ACCESS=1, act as QUAL completion in the same edge; otherwise go to QUAL.
  - QUAL: if the strobe that started qualification drops, go to IDLE with no pulse and cnt=0. Otherwise cnt++; when cnt reaches MIN_ACCESS, complete.
  - Completion, on the same edge:
    - Both wr_s and rd_s high: access_error=1, no data pulse, go to HOLD.
    - Else if hit: drive a 1 on writePulse[ch] or readPulse[ch], set pulse_channel=ch, go to HOLD.
    - Else: miss_count++ (saturate at all-ones), go to HOLD.
  - HOLD: all pulses return to 0 on the next edge. Stay in HOLD until wr_s=0 and rd_s=0, then go to IDLE. A long strobe produces exactly one pulse.
- Latency: if edge 0 is the first edge that samples the raw strobe high (stable thereafter), the pulse is high between edges SYNC_STAGES+MIN_ACCESS-1 and SYNC_STAGES+MIN_ACCESS. SYNC_STAGES=0 with MIN_ACCESS=1 gives a pulse registered on edge 0.
- Pulses are always one cycle wide. At most one bit of writePulse|readPulse is set at any time.
- Strobe roles:
  - A strobe rising during HOLD is ignored.
  - The opposite strobe rising during QUAL does not restart the counter; it is evaluated only at completion, where it produces a collision.
- base_address changes take effect on the next decode. They must be static during an access; a change mid-access is undefined and need not be handled.
- init asserted in any state: all outputs reach their reset values on that edge. Any in-progress pulse or count is discarded.

Test Plan:
- Defaults, base_address=0x0100, write to 0x0104 for 10 cycles -> writePulse=8'b0000_0100 for exactly 1 cycle, 3 cycles after the first sampling edge; pulse_channel=2; readPulse stays 0.
- Read at 0x0100 held 50 cycles, released, then repeated -> exactly two readPulse[0] pulses, one per strobe.
- Write strobe high for 1 cycle (shorter than MIN_ACCESS=2 after sync) -> no pulse, FSM back to IDLE, miss_count unchanged.
- Qualified accesses at 0x0101 (misaligned), 0x0110 (past the window) and 0x00FE (below base, wraps) -> no pulses; miss_count=3. With MISS_W=2, five misses -> miss_count=3 (saturated).
- readAccess and writeAccess both asserted at 0x0102 -> access_error high for 1 cycle; no write or read pulse.
- init pulsed while writeAccess is held high at a hit address -> no pulse after reset until the strobe drops and rises again. The second rise yields one pulse; base_address=0xFFFE with address 0x0000 -> pulse on channel 1.

Source files
------------

// File: rtl/gf_vme_multi_pulse_decoder_if.sv
// rtl/gf_vme_multi_pulse_decoder_if.sv - VME access strobes/address and decoded pulse bundle
interface gf_vme_multi_pulse_decoder_if #(
  parameter int ADDR_W = 16,
  parameter int N_CH   = 8,
  parameter int MISS_W = 8,
  parameter int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
);
  logic [ADDR_W-1:0] address;
  logic [ADDR_W-1:0] base_address;
  logic              writeAccess;
  logic              readAccess;
  logic [N_CH-1:0]   writePulse;
  logic [N_CH-1:0]   readPulse;
  logic [CH_W-1:0]   pulse_channel;
  logic              access_error;
  logic [MISS_W-1:0] miss_count;

  modport master (
    output address, base_address, writeAccess, readAccess,
    input  writePulse, readPulse, pulse_channel, access_error, miss_count
  );

  modport slave (
    input  address, base_address, writeAccess, readAccess,
    output writePulse, readPulse, pulse_channel, access_error, miss_count
  );
endinterface

// File: rtl/gf_vme_multi_pulse_decoder.sv
// rtl/gf_vme_multi_pulse_decoder.sv - VME window decoder: synchronised, deglitched one-hot read/write pulses
module gf_vme_multi_pulse_decoder #(
  parameter int ADDR_W      = 16,
  parameter int N_CH        = 8,
  parameter int STRIDE_LOG2 = 1,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_ACCESS  = 2,
  parameter int MISS_W      = 8
) (
  input logic clk,
  input logic init,
  gf_vme_multi_pulse_decoder_if.slave bus
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int ARM_LEN = SYNC_STAGES + 1;
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((1 << STRIDE_LOG2) - 1);

  typedef enum logic [1:0] {ARM, IDLE, QUAL, HOLD} state_t;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              start_wr_q;
  logic [N_CH-1:0]   wr_pulse_q;
  logic [N_CH-1:0]   rd_pulse_q;
  logic [CH_W-1:0]   ch_q;
  logic              err_q;
  logic [MISS_W-1:0] miss_q;

  logic              wr_s;
  logic              rd_s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign wr_s = bus.writeAccess;
      assign rd_s = bus.readAccess;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] wr_sync_q;
      logic [SYNC_STAGES-1:0] rd_sync_q;
      always_ff @(posedge clk) begin
        if (init) begin
          wr_sync_q <= '0;
          rd_sync_q <= '0;
        end else begin
          wr_sync_q <= (wr_sync_q << 1) | SYNC_STAGES'(bus.writeAccess);
          rd_sync_q <= (rd_sync_q << 1) | SYNC_STAGES'(bus.readAccess);
        end
      end
      assign wr_s = wr_sync_q[SYNC_STAGES-1];
      assign rd_s = rd_sync_q[SYNC_STAGES-1];
    end
  endgenerate

  logic [ADDR_W-1:0] off;
  logic [ADDR_W-1:0] idx;
  logic              hit;
  logic [CH_W-1:0]   ch;

  assign off = bus.address - bus.base_address;
  assign idx = off >> STRIDE_LOG2;
  assign hit = (idx < ADDR_W'(N_CH)) && ((off & LOW_MASK) == '0);
  assign ch  = idx[CH_W-1:0];

  logic       start_s;
  logic       dir_wr;
  logic [3:0] cnt_inc;
  logic       done;

  assign start_s = start_wr_q ? wr_s : rd_s;
  assign dir_wr  = (state_q == IDLE) ? wr_s : start_wr_q;
  assign cnt_inc = cnt_q + 4'd1;

  always_comb begin
    done = 1'b0;
    case (state_q)
      IDLE:    done = (wr_s || rd_s) && (MIN_ACCESS == 1);
      QUAL:    done = start_s && (cnt_inc == 4'(MIN_ACCESS));
      default: done = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (init) begin
      state_q    <= ARM;
      cnt_q      <= '0;
      start_wr_q <= 1'b0;
      wr_pulse_q <= '0;
      rd_pulse_q <= '0;
      ch_q       <= '0;
      err_q      <= 1'b0;
      miss_q     <= '0;
    end else begin
      wr_pulse_q <= '0;
      rd_pulse_q <= '0;
      err_q      <= 1'b0;
      case (state_q)
        // The synchroniser is flushed by init, so strobes must read low for a
        // full refill of the chain before the idle state is trusted.
        ARM: begin
          if (wr_s || rd_s) begin
            cnt_q <= '0;
          end else if (cnt_q == 4'(ARM_LEN - 1)) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        IDLE: begin
          if (wr_s || rd_s) begin
            start_wr_q <= wr_s;
            cnt_q      <= 4'd1;
            state_q    <= QUAL;
          end
        end
        QUAL: begin
          if (!start_s) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        HOLD: begin
          if (!wr_s && !rd_s) state_q <= IDLE;
        end
        default: state_q <= ARM;
      endcase

      if (done) begin
        cnt_q   <= '0;
        state_q <= HOLD;
        if (wr_s && rd_s) begin
          err_q <= 1'b1;
        end else if (hit) begin
          if (dir_wr) wr_pulse_q <= N_CH'(1) << ch;
          else        rd_pulse_q <= N_CH'(1) << ch;
          ch_q <= ch;
        end else if (miss_q != '1) begin
          miss_q <= miss_q + MISS_W'(1);
        end
      end
    end
  end

  assign bus.writePulse    = wr_pulse_q;
  assign bus.readPulse     = rd_pulse_q;
  assign bus.pulse_channel = ch_q;
  assign bus.access_error  = err_q;
  assign bus.miss_count    = miss_q;
endmodule

// File: tb/tb_gf_vme_multi_pulse_decoder.sv
// tb/tb_gf_vme_multi_pulse_decoder.sv - directed vector bench for the VME multi-pulse decoder
module tb_gf_vme_multi_pulse_decoder;
  logic clk = 1'b0;
  logic init;
  always #5 clk = ~clk;

  gf_vme_multi_pulse_decoder_if #(.ADDR_W(16), .N_CH(8), .MISS_W(8)) bus_a ();
  gf_vme_multi_pulse_decoder_if #(.ADDR_W(16), .N_CH(8), .MISS_W(2)) bus_b ();

  assign bus_b.address      = bus_a.address;
  assign bus_b.base_address = bus_a.base_address;
  assign bus_b.writeAccess  = bus_a.writeAccess;
  assign bus_b.readAccess   = bus_a.readAccess;

  gf_vme_multi_pulse_decoder #(.MISS_W(8)) dut_a (.clk(clk), .init(init), .bus(bus_a));
  gf_vme_multi_pulse_decoder #(.MISS_W(2)) dut_b (.clk(clk), .init(init), .bus(bus_b));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int start_cyc;
  int wr_n, rd_n, err_n, multi_n, lat;
  logic [7:0] pat;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (|bus_a.writePulse) wr_n++;
    if (|bus_a.readPulse) rd_n++;
    if (bus_a.access_error) err_n++;
    if ($countones(bus_a.writePulse | bus_a.readPulse) > 1) multi_n++;
    pat = pat | bus_a.writePulse | bus_a.readPulse;
    if ((|(bus_a.writePulse | bus_a.readPulse)) && lat < 0) lat = cyc - start_cyc;
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    wr_n = 0; rd_n = 0; err_n = 0; multi_n = 0; lat = -1; pat = '0;
  endtask

  task automatic run_access(input logic [15:0] addr, input logic [15:0] base,
                            input logic wr, input logic rd, input int hold);
    @(posedge clk); #1;
    bus_a.address      = addr;
    bus_a.base_address = base;
    clear_mon();
    start_cyc = cyc + 1;
    bus_a.writeAccess = wr;
    bus_a.readAccess  = rd;
    repeat (hold) @(posedge clk);
    #1;
    bus_a.writeAccess = 1'b0;
    bus_a.readAccess  = 1'b0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [15:0] base;
    logic        wr;
    logic        rd;
    int          hold;
    int          exp_wr_n;
    int          exp_rd_n;
    int          exp_err_n;
    logic [7:0]  exp_pat;
    int          exp_ch;
    int          exp_miss;
    int          exp_lat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    // expected miss_count is cumulative across the table
    vecs[0]  = '{16'h0104, 16'h0100, 1'b1, 1'b0, 10, 1, 0, 0, 8'h04, 2, 0, 3};
    vecs[1]  = '{16'h0100, 16'h0100, 1'b0, 1'b1, 50, 0, 1, 0, 8'h01, 0, 0, 3};
    vecs[2]  = '{16'h0100, 16'h0100, 1'b0, 1'b1, 50, 0, 1, 0, 8'h01, 0, 0, 3};
    vecs[3]  = '{16'h0104, 16'h0100, 1'b1, 1'b0,  1, 0, 0, 0, 8'h00, 0, 0, -1};
    vecs[4]  = '{16'h0101, 16'h0100, 1'b1, 1'b0, 10, 0, 0, 0, 8'h00, 0, 1, -1};
    vecs[5]  = '{16'h0110, 16'h0100, 1'b1, 1'b0, 10, 0, 0, 0, 8'h00, 0, 2, -1};
    vecs[6]  = '{16'h00FE, 16'h0100, 1'b0, 1'b1, 10, 0, 0, 0, 8'h00, 0, 3, -1};
    vecs[7]  = '{16'h0102, 16'h0100, 1'b1, 1'b1, 10, 0, 0, 1, 8'h00, 0, 3, -1};
    vecs[8]  = '{16'h010E, 16'h0100, 1'b1, 1'b0,  5, 1, 0, 0, 8'h80, 7, 3, 3};
    vecs[9]  = '{16'h0000, 16'hFFFE, 1'b0, 1'b1, 10, 0, 1, 0, 8'h02, 1, 3, 3};
    vecs[10] = '{16'h010F, 16'h0100, 1'b1, 1'b0,  5, 0, 0, 0, 8'h00, 1, 4, -1};
    vecs[11] = '{16'h0080, 16'h0100, 1'b0, 1'b1,  5, 0, 0, 0, 8'h00, 1, 5, -1};

    init = 1'b1;
    bus_a.address      = '0;
    bus_a.base_address = 16'h0100;
    bus_a.writeAccess  = 1'b0;
    bus_a.readAccess   = 1'b0;
    clear_mon();
    repeat (2) @(posedge clk);
    #1;
    check("reset writePulse", int'(bus_a.writePulse), 0);
    check("reset readPulse", int'(bus_a.readPulse), 0);
    check("reset pulse_channel", int'(bus_a.pulse_channel), 0);
    check("reset access_error", int'(bus_a.access_error), 0);
    check("reset miss_count", int'(bus_a.miss_count), 0);
    init = 1'b0;
    repeat (5) @(posedge clk);

    for (int i = 0; i < 12; i++) begin
      run_access(vecs[i].addr, vecs[i].base, vecs[i].wr, vecs[i].rd, vecs[i].hold);
      check($sformatf("v%0d write pulses", i), wr_n, vecs[i].exp_wr_n);
      check($sformatf("v%0d read pulses", i), rd_n, vecs[i].exp_rd_n);
      check($sformatf("v%0d error pulses", i), err_n, vecs[i].exp_err_n);
      check($sformatf("v%0d multi-hot", i), multi_n, 0);
      check($sformatf("v%0d pulse pattern", i), int'(pat), int'(vecs[i].exp_pat));
      check($sformatf("v%0d pulse_channel", i), int'(bus_a.pulse_channel), vecs[i].exp_ch);
      check($sformatf("v%0d miss_count", i), int'(bus_a.miss_count), vecs[i].exp_miss);
      check($sformatf("v%0d miss_count sat", i), int'(bus_b.miss_count),
            (vecs[i].exp_miss > 3) ? 3 : vecs[i].exp_miss);
      check($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
    end

    // init while a write strobe is held at a hit address
    @(posedge clk); #1;
    bus_a.address      = 16'h0104;
    bus_a.base_address = 16'h0100;
    bus_a.writeAccess  = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    check("init writePulse", int'(bus_a.writePulse), 0);
    check("init pulse_channel", int'(bus_a.pulse_channel), 0);
    check("init miss_count", int'(bus_a.miss_count), 0);
    check("init miss_count sat", int'(bus_b.miss_count), 0);
    clear_mon();
    repeat (20) @(posedge clk);
    #1;
    check("held after init pulses", wr_n, 0);
    bus_a.writeAccess = 1'b0;
    repeat (8) @(posedge clk);

    run_access(16'h0000, 16'hFFFE, 1'b1, 1'b0, 10);
    check("rearm write pulses", wr_n, 1);
    check("rearm pattern", int'(pat), 8'h02);
    check("rearm pulse_channel", int'(bus_a.pulse_channel), 1);
    check("rearm latency", lat, 3);
    check("rearm read pulses", rd_n, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
